// File: rtl/bp_me_cache_dma_arbiter.sv
// ---------------------------------------------------------------------------
// bp_me_cache_dma_arbiter
//
// Merges the DMA ports of several bsg_cache slices onto a single memory DMA
// port. Packets are granted round-robin. A write grant holds the command side
// until the whole block of write data has been handed to memory. A read grant
// records the requesting slice in a tag FIFO so read data can be steered back
// to the right slice. Read data is steered independently of the command side,
// so read returns can overlap write data.
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   dma_pkt_i / _v_i / _yumi_o    per-slice {write_not_read, addr} packets
//   dma_data_i / _v_i / _yumi_o   per-slice write data
//   dma_data_o                read data, broadcast to every slice
//   dma_data_v_o / _ready_i   per-slice read data handshake
//   mem_pkt_o / _v_o / _yumi_i    arbitrated packet towards memory
//   mem_data_o / _v_o / _yumi_i   write data towards memory
//   mem_data_i / _v_i / _ready_o  read data from memory
// ---------------------------------------------------------------------------
module bp_me_cache_dma_arbiter #(
    parameter int num_slices_p          = 4,
    parameter int addr_width_p          = 40,
    parameter int data_width_p          = 64,
    parameter int block_size_in_words_p = 8,
    parameter int max_outstanding_p     = 4
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,

    input  logic [num_slices_p*(addr_width_p+1)-1:0]  dma_pkt_i,
    input  logic [num_slices_p-1:0]                    dma_pkt_v_i,
    output logic [num_slices_p-1:0]                    dma_pkt_yumi_o,

    input  logic [num_slices_p*data_width_p-1:0]       dma_data_i,
    input  logic [num_slices_p-1:0]                    dma_data_v_i,
    output logic [num_slices_p-1:0]                    dma_data_yumi_o,

    output logic [data_width_p-1:0]                    dma_data_o,
    output logic [num_slices_p-1:0]                    dma_data_v_o,
    input  logic [num_slices_p-1:0]                    dma_data_ready_i,

    output logic [addr_width_p:0]                      mem_pkt_o,
    output logic                                       mem_pkt_v_o,
    input  logic                                       mem_pkt_yumi_i,

    output logic [data_width_p-1:0]                    mem_data_o,
    output logic                                       mem_data_v_o,
    input  logic                                       mem_data_yumi_i,

    input  logic [data_width_p-1:0]                    mem_data_i,
    input  logic                                       mem_data_v_i,
    output logic                                       mem_data_ready_o
);

    localparam int pkt_width_lp      = addr_width_p + 1;
    localparam int slice_id_width_lp = $clog2(num_slices_p);
    localparam int cnt_width_lp      = $clog2(block_size_in_words_p);
    localparam int fifo_ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int fifo_cnt_width_lp = $clog2(max_outstanding_p + 1);

    localparam logic [slice_id_width_lp:0]   num_slices_lp = (slice_id_width_lp+1)'(num_slices_p);
    localparam logic [slice_id_width_lp-1:0] last_slice_lp = slice_id_width_lp'(num_slices_p - 1);
    localparam logic [cnt_width_lp-1:0]      last_word_lp  = cnt_width_lp'(block_size_in_words_p - 1);
    localparam logic [fifo_ptr_width_lp-1:0] last_slot_lp  = fifo_ptr_width_lp'(max_outstanding_p - 1);
    localparam logic [fifo_cnt_width_lp-1:0] fifo_depth_lp = fifo_cnt_width_lp'(max_outstanding_p);

    typedef enum logic {IDLE, WR_DATA} state_e;

    state_e                         state;
    logic [slice_id_width_lp-1:0]   rr_ptr;
    logic [slice_id_width_lp-1:0]   owner;
    logic [cnt_width_lp-1:0]        wr_cnt;
    logic [cnt_width_lp-1:0]        rd_cnt;

    logic [pkt_width_lp-1:0]        pkt_arr  [num_slices_p];
    logic [data_width_p-1:0]        data_arr [num_slices_p];
    logic [num_slices_p-1:0]        pkt_is_write;
    logic [num_slices_p-1:0]        eligible;

    logic [slice_id_width_lp:0]     cand_wide;
    logic [slice_id_width_lp-1:0]   cand;
    logic [slice_id_width_lp-1:0]   sel;
    logic                           sel_found;

    logic [slice_id_width_lp-1:0]   tag_mem [max_outstanding_p];
    logic [fifo_ptr_width_lp-1:0]   tag_rd;
    logic [fifo_ptr_width_lp-1:0]   tag_wr;
    logic [fifo_cnt_width_lp-1:0]   tag_cnt;
    logic                           tag_full;
    logic                           tag_empty;
    logic                           tag_push;
    logic                           tag_pop;
    logic [slice_id_width_lp-1:0]   head;

    logic                           in_wr;
    logic                           pkt_accept;
    logic                           wr_beat;
    logic                           rd_beat;

    // Unflatten the per-slice buses.
    always_comb begin
        for (int i = 0; i < num_slices_p; i++) begin
            pkt_arr[i]      = dma_pkt_i[i*pkt_width_lp +: pkt_width_lp];
            data_arr[i]     = dma_data_i[i*data_width_p +: data_width_p];
            pkt_is_write[i] = pkt_arr[i][addr_width_p];
        end
    end

    assign tag_full  = (tag_cnt == fifo_depth_lp);
    assign tag_empty = (tag_cnt == '0);
    assign head      = tag_mem[tag_rd];
    assign in_wr     = (state == WR_DATA);

    // Reads are masked while the tag FIFO is full; writes never need a tag.
    assign eligible = dma_pkt_v_i & (pkt_is_write | {num_slices_p{~tag_full}});

    // Round-robin search starting at rr_ptr.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        cand_wide = '0;
        cand      = '0;
        for (int k = 0; k < num_slices_p; k++) begin
            cand_wide = {1'b0, rr_ptr} + (slice_id_width_lp+1)'(k);
            if (cand_wide >= num_slices_lp) begin
                cand_wide = cand_wide - num_slices_lp;
            end
            cand = cand_wide[slice_id_width_lp-1:0];
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel       = cand;
            end
        end
    end

    // Command side. Valid is also qualified by reset_n_i so no grant is
    // offered while reset is held, even with requesters active.
    always_comb begin
        mem_pkt_o       = pkt_arr[sel];
        mem_pkt_v_o     = reset_n_i & (state == IDLE) & sel_found;
        pkt_accept      = mem_pkt_v_o & mem_pkt_yumi_i;
        dma_pkt_yumi_o  = '0;
        if (pkt_accept) begin
            dma_pkt_yumi_o[sel] = 1'b1;
        end

        mem_data_o      = data_arr[owner];
        mem_data_v_o    = in_wr & dma_data_v_i[owner];
        dma_data_yumi_o = '0;
        if (in_wr) begin
            dma_data_yumi_o[owner] = mem_data_yumi_i;
        end
        wr_beat         = in_wr & mem_data_yumi_i;
    end

    // Read-response side, steered by the head of the tag FIFO.
    always_comb begin
        dma_data_o       = mem_data_i;
        dma_data_v_o     = '0;
        mem_data_ready_o = 1'b0;
        if (!tag_empty) begin
            dma_data_v_o[head] = mem_data_v_i;
            mem_data_ready_o   = dma_data_ready_i[head];
        end
        rd_beat  = mem_data_v_i & mem_data_ready_o;
        tag_pop  = rd_beat & (rd_cnt == last_word_lp);
        tag_push = pkt_accept & ~pkt_is_write[sel];
    end

    // Command FSM.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            wr_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pkt_accept) begin
                        rr_ptr <= (sel == last_slice_lp) ? '0 : sel + 1'b1;
                        if (pkt_is_write[sel]) begin
                            owner  <= sel;
                            wr_cnt <= '0;
                            state  <= WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (wr_beat) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == last_word_lp) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag FIFO pointers and read word counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tag_rd  <= '0;
            tag_wr  <= '0;
            tag_cnt <= '0;
            rd_cnt  <= '0;
        end else begin
            if (tag_push) begin
                tag_wr <= (tag_wr == last_slot_lp) ? '0 : tag_wr + 1'b1;
            end
            if (tag_pop) begin
                tag_rd <= (tag_rd == last_slot_lp) ? '0 : tag_rd + 1'b1;
            end
            case ({tag_push, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
            if (rd_beat) begin
                rd_cnt <= tag_pop ? '0 : rd_cnt + 1'b1;
            end
        end
    end

    // NOTE: the tag storage is deliberately not reset; entries are only read
    // when tag_cnt says they were written, and resetting pointers suffices.
    always_ff @(posedge clk_i) begin
        if (tag_push) begin
            tag_mem[tag_wr] <= sel;
        end
    end

endmodule

// File: tb/tb_bp_me_cache_dma_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for bp_me_cache_dma_arbiter. Directed scenarios followed by
// randomized traffic; every cycle the DUT outputs are compared against a
// behavioural model holding a round-robin pointer, a write word countdown and
// a queue of outstanding read tags.
// ---------------------------------------------------------------------------
module tb_bp_me_cache_dma_arbiter;

    localparam int N  = 4;
    localparam int AW = 40;
    localparam int DW = 64;
    localparam int B  = 8;
    localparam int MO = 4;
    localparam int PW = AW + 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N*PW-1:0]   dma_pkt_i;
    logic [N-1:0]      dma_pkt_v_i;
    logic [N-1:0]      dma_pkt_yumi_o;
    logic [N*DW-1:0]   dma_data_i;
    logic [N-1:0]      dma_data_v_i;
    logic [N-1:0]      dma_data_yumi_o;
    logic [DW-1:0]     dma_data_o;
    logic [N-1:0]      dma_data_v_o;
    logic [N-1:0]      dma_data_ready_i;
    logic [PW-1:0]     mem_pkt_o;
    logic              mem_pkt_v_o;
    logic              mem_pkt_yumi_i;
    logic [DW-1:0]     mem_data_o;
    logic              mem_data_v_o;
    logic              mem_data_yumi_i;
    logic [DW-1:0]     mem_data_i;
    logic              mem_data_v_i;
    logic              mem_data_ready_o;

    always #5 clk = ~clk;

    bp_me_cache_dma_arbiter #(
        .num_slices_p          (N),
        .addr_width_p          (AW),
        .data_width_p          (DW),
        .block_size_in_words_p (B),
        .max_outstanding_p     (MO)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .dma_pkt_i        (dma_pkt_i),
        .dma_pkt_v_i      (dma_pkt_v_i),
        .dma_pkt_yumi_o   (dma_pkt_yumi_o),
        .dma_data_i       (dma_data_i),
        .dma_data_v_i     (dma_data_v_i),
        .dma_data_yumi_o  (dma_data_yumi_o),
        .dma_data_o       (dma_data_o),
        .dma_data_v_o     (dma_data_v_o),
        .dma_data_ready_i (dma_data_ready_i),
        .mem_pkt_o        (mem_pkt_o),
        .mem_pkt_v_o      (mem_pkt_v_o),
        .mem_pkt_yumi_i   (mem_pkt_yumi_i),
        .mem_data_o       (mem_data_o),
        .mem_data_v_o     (mem_data_v_o),
        .mem_data_yumi_i  (mem_data_yumi_i),
        .mem_data_i       (mem_data_i),
        .mem_data_v_i     (mem_data_v_i),
        .mem_data_ready_o (mem_data_ready_o)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int  m_ptr;
    bit  m_in_write;
    int  m_owner;
    int  m_left;
    int  m_tags[$];
    int  m_rd_words;

    bit  e_acc, e_acc_wr, e_wr_hs, e_rd_hs;

    task automatic model_reset();
        m_ptr      = 0;
        m_in_write = 0;
        m_owner    = 0;
        m_left     = 0;
        m_tags.delete();
        m_rd_words = 0;
    endtask

    task automatic set_pkt(input int s, input bit wnr, input logic [AW-1:0] addr);
        dma_pkt_i[s*PW +: PW] = {wnr, addr};
    endtask

    task automatic set_data(input int s, input logic [DW-1:0] d);
        dma_data_i[s*DW +: DW] = d;
    endtask

    task automatic clear_inputs();
        dma_pkt_i        = '0;
        dma_pkt_v_i      = '0;
        dma_data_i       = '0;
        dma_data_v_i     = '0;
        dma_data_ready_i = '0;
        mem_pkt_yumi_i   = 1'b0;
        mem_data_yumi_i  = 1'b0;
        mem_data_i       = '0;
        mem_data_v_i     = 1'b0;
    endtask

    // Computes expected outputs for the inputs currently applied, drives the
    // memory-side yumis (only when the model expects a valid), then compares.
    task automatic eval_and_check(input bit want_pkt_yumi, input bit want_data_yumi);
        logic [N-1:0]  exp_pkt_yumi, exp_data_yumi, exp_rd_v;
        logic [PW-1:0] exp_pkt;
        logic [DW-1:0] exp_wdata;
        bit            exp_pkt_v, exp_wv, exp_ready, full;
        int            sel_s, h;
        full      = (m_tags.size() >= MO);
        exp_pkt_v = 0;
        sel_s     = 0;
        if (!m_in_write) begin
            for (int k = 0; k < N; k++) begin
                int j = (m_ptr + k) % N;
                if (!exp_pkt_v && dma_pkt_v_i[j] && (dma_pkt_i[j*PW + AW] || !full)) begin
                    exp_pkt_v = 1;
                    sel_s     = j;
                end
            end
        end
        mem_pkt_yumi_i = want_pkt_yumi & exp_pkt_v;
        exp_pkt        = dma_pkt_i[sel_s*PW +: PW];
        exp_pkt_yumi   = '0;
        if (mem_pkt_yumi_i) exp_pkt_yumi[sel_s] = 1'b1;

        exp_wv          = m_in_write && dma_data_v_i[m_owner];
        mem_data_yumi_i = want_data_yumi & exp_wv;
        exp_wdata       = dma_data_i[m_owner*DW +: DW];
        exp_data_yumi   = '0;
        if (m_in_write && mem_data_yumi_i) exp_data_yumi[m_owner] = 1'b1;

        exp_rd_v  = '0;
        exp_ready = 0;
        if (m_tags.size() > 0) begin
            h         = m_tags[0];
            exp_ready = dma_data_ready_i[h];
            if (mem_data_v_i) exp_rd_v[h] = 1'b1;
        end

        #1;
        check("pkt_v", 64'(mem_pkt_v_o), 64'(exp_pkt_v));
        if (exp_pkt_v) check("pkt", 64'(mem_pkt_o), 64'(exp_pkt));
        check("pkt_yumi", 64'(dma_pkt_yumi_o), 64'(exp_pkt_yumi));
        check("wdata_v", 64'(mem_data_v_o), 64'(exp_wv));
        if (m_in_write) check("wdata", mem_data_o, exp_wdata);
        check("wdata_yumi", 64'(dma_data_yumi_o), 64'(exp_data_yumi));
        check("rdata_v", 64'(dma_data_v_o), 64'(exp_rd_v));
        check("rdata_ready", 64'(mem_data_ready_o), 64'(exp_ready));
        check("rdata", dma_data_o, mem_data_i);

        e_acc    = exp_pkt_v && mem_pkt_yumi_i;
        e_acc_wr = e_acc && dma_pkt_i[sel_s*PW + AW];
        e_wr_hs  = m_in_write && mem_data_yumi_i;
        e_rd_hs  = exp_ready && mem_data_v_i;
        if (e_acc) begin
            m_ptr = (sel_s + 1) % N;
            if (e_acc_wr) begin
                m_owner = sel_s;
            end
        end
    endtask

    task automatic model_update();
        if (e_acc) begin
            if (e_acc_wr) begin
                m_in_write = 1;
                m_left     = B;
            end else begin
                m_tags.push_back((m_ptr + N - 1) % N);
            end
        end
        if (e_wr_hs) begin
            m_left--;
            if (m_left == 0) m_in_write = 0;
        end
        if (e_rd_hs) begin
            m_rd_words++;
            if (m_rd_words == B) begin
                m_rd_words = 0;
                void'(m_tags.pop_front());
            end
        end
    endtask

    // One clock: called at a negedge with inputs applied, returns at the next.
    task automatic cycle(input bit py, input bit dy);
        eval_and_check(py, dy);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic cycle_expect_grant(input logic [N-1:0] g);
        eval_and_check(1'b1, 1'b1);
        check("grant", 64'(dma_pkt_yumi_o), 64'(g));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle with memory yumis high, checks every valid and
    // yumi drops at once, then releases on the following negedge.
    task automatic do_reset();
        reset_n         = 1'b0;
        mem_pkt_yumi_i  = 1'b1;
        mem_data_yumi_i = 1'b1;
        #1;
        check("rst_pkt_v", 64'(mem_pkt_v_o), 64'd0);
        check("rst_wdata_v", 64'(mem_data_v_o), 64'd0);
        check("rst_ready", 64'(mem_data_ready_o), 64'd0);
        check("rst_rdata_v", 64'(dma_data_v_o), 64'd0);
        check("rst_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
        check("rst_data_yumi", 64'(dma_data_yumi_o), 64'd0);
        model_reset();
        @(negedge clk);
        reset_n         = 1'b1;
        mem_pkt_yumi_i  = 1'b0;
        mem_data_yumi_i = 1'b0;
    endtask

    int pp[4]  = '{50, 90, 30, 100};
    int wp[4]  = '{30, 10, 70, 50};
    int yp[4]  = '{70, 90, 50, 100};
    int dvp[4] = '{80, 90, 60, 100};
    int dyp[4] = '{80, 90, 60, 100};
    int rvp[4] = '{50, 10, 80, 100};
    int ryp[4] = '{70, 50, 90, 100};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] rnd;
        clear_inputs();
        model_reset();
        @(negedge clk);
        do_reset();
        cycle(1, 1);

        // Single write from slice 2.
        set_pkt(2, 1'b1, 40'h00_8000_0040);
        dma_pkt_v_i  = 4'b0100;
        dma_data_v_i = 4'b0100;
        eval_and_check(1'b1, 1'b1);
        check("wr_pkt", 64'(mem_pkt_o), 64'h1_0080_0000_40 >> 0 == 64'h0 ? 64'h0 : {23'd0, 1'b1, 40'h00_8000_0040});
        @(posedge clk); model_update(); @(negedge clk);
        dma_pkt_v_i = '0;
        for (int w = 0; w < B + 1; w++) begin
            set_data(2, 64'hD0D0_0000_0000_0000 + 64'(w));
            cycle(1, 1);
        end
        dma_data_v_i = '0;
        set_pkt(0, 1'b0, 40'h11);
        set_pkt(3, 1'b0, 40'h33);
        dma_pkt_v_i = 4'b1001;
        cycle_expect_grant(4'b1000);
        dma_pkt_v_i = '0;

        // Fairness with all slices reading; FIFO fills after four grants.
        do_reset();
        for (int s = 0; s < N; s++) set_pkt(s, 1'b0, 40'(s * 64));
        dma_pkt_v_i = 4'b1111;
        cycle_expect_grant(4'b0001);
        cycle_expect_grant(4'b0010);
        cycle_expect_grant(4'b0100);
        cycle_expect_grant(4'b1000);
        cycle_expect_grant(4'b0000);
        cycle_expect_grant(4'b0000);
        mem_data_v_i     = 1'b1;
        dma_data_ready_i = 4'b1111;
        for (int w = 0; w < B; w++) begin
            mem_data_i = 64'hA000 + 64'(w);
            cycle_expect_grant(4'b0000);
        end
        cycle_expect_grant(4'b0001);
        clear_inputs();

        // Slice 1 read data overlapping slice 3 write data.
        do_reset();
        set_pkt(1, 1'b0, 40'h100);
        set_pkt(3, 1'b1, 40'h300);
        dma_pkt_v_i = 4'b1010;
        cycle_expect_grant(4'b0010);
        dma_pkt_v_i = 4'b1000;
        cycle_expect_grant(4'b1000);
        dma_pkt_v_i      = '0;
        dma_data_v_i     = 4'b1000;
        mem_data_v_i     = 1'b1;
        dma_data_ready_i = 4'b1111;
        for (int w = 0; w < B + 1; w++) begin
            set_data(3, 64'hBEEF_0000 + 64'(w));
            mem_data_i = 64'hCAFE_0000 + 64'(w);
            cycle(1, 1);
        end
        check("interleave_empty", 64'(dma_data_v_o), 64'd0);
        clear_inputs();

        // Read backpressure on slice 0.
        do_reset();
        set_pkt(0, 1'b0, 40'h40);
        dma_pkt_v_i = 4'b0001;
        cycle_expect_grant(4'b0001);
        dma_pkt_v_i  = '0;
        mem_data_v_i = 1'b1;
        for (int w = 0; w < 5; w++) begin
            mem_data_i = 64'h5500 + 64'(w);
            cycle(1, 1);
        end
        dma_data_ready_i = 4'b0001;
        for (int w = 0; w < B + 1; w++) begin
            mem_data_i = 64'h6600 + 64'(w);
            cycle(1, 1);
        end
        clear_inputs();

        // Full tag FIFO does not block a write.
        do_reset();
        for (int s = 0; s < N; s++) set_pkt(s, 1'b0, 40'(s * 128));
        dma_pkt_v_i = 4'b1111;
        for (int s = 0; s < N; s++) cycle_expect_grant(4'(1 << s));
        set_pkt(2, 1'b1, 40'h2222);
        cycle_expect_grant(4'b0100);
        dma_pkt_v_i      = '0;
        dma_data_v_i     = 4'b0100;
        mem_data_v_i     = 1'b1;
        dma_data_ready_i = 4'b1111;
        for (int w = 0; w < N * B + 2; w++) begin
            set_data(2, 64'h7700 + 64'(w));
            mem_data_i = 64'h8800 + 64'(w);
            cycle(1, 1);
        end
        clear_inputs();

        // Reset in the middle of a write, then an immediate slice 0 read.
        do_reset();
        set_pkt(0, 1'b1, 40'h900);
        dma_pkt_v_i  = 4'b0001;
        dma_data_v_i = 4'b0001;
        cycle_expect_grant(4'b0001);
        dma_pkt_v_i = '0;
        for (int w = 0; w < 3; w++) begin
            set_data(0, 64'h9900 + 64'(w));
            cycle(1, 1);
        end
        do_reset();
        set_pkt(0, 1'b0, 40'h980);
        dma_pkt_v_i = 4'b0001;
        cycle_expect_grant(4'b0001);
        clear_inputs();
        cycle(1, 1);

        // Randomized traffic in four regimes.
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 600; c++) begin
                for (int s = 0; s < N; s++) begin
                    rnd = {$urandom, $urandom};
                    dma_pkt_v_i[s]      = ($urandom_range(0, 99) < pp[ph]);
                    set_pkt(s, ($urandom_range(0, 99) < wp[ph]), rnd[AW-1:0]);
                    set_data(s, {$urandom, $urandom});
                    dma_data_v_i[s]     = ($urandom_range(0, 99) < dvp[ph]);
                    dma_data_ready_i[s] = ($urandom_range(0, 99) < ryp[ph]);
                end
                mem_data_i   = {$urandom, $urandom};
                mem_data_v_i = ($urandom_range(0, 99) < rvp[ph]);
                if ($urandom_range(0, 299) == 0) do_reset();
                cycle(($urandom_range(0, 99) < yp[ph]), ($urandom_range(0, 99) < dyp[ph]));
            end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
